// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default widths, master FSM states and the
// termination priority encoding used by master- and slave-side blocks.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2
  } wbm_state_e;

  // Ordered by increasing priority so a larger code always wins.
  typedef enum logic [1:0] {
    TERM_NONE = 2'd0,
    TERM_RTY  = 2'd1,
    TERM_ACK  = 2'd2,
    TERM_ERR  = 2'd3
  } wb_term_e;

  function automatic wb_term_e wb_term_decode(input logic err, input logic ack, input logic rty);
    if (err)      return TERM_ERR;
    else if (ack) return TERM_ACK;
    else if (rty) return TERM_RTY;
    else          return TERM_NONE;
  endfunction

endpackage

// File: rtl/wbm_ctrl_if.sv
// Core request/response handshake plus the Wishbone classic master bus,
// bundled so the master and its testbench or interconnect share one view.
interface wbm_ctrl_if #(
  parameter int unsigned ADDR_W = wb_pkg::WB_ADDR_W,
  parameter int unsigned DATA_W = wb_pkg::WB_DATA_W
) ();

  localparam int unsigned SEL_W = DATA_W / 8;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_dat_i;
  logic [SEL_W-1:0]  req_sel_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_dat_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [ADDR_W-1:0] wbm_addr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [SEL_W-1:0]  wbm_sel_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;
  logic              wbm_err_i;
  logic              wbm_rty_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_dat_i, req_sel_i,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_dat_i, req_sel_i,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_dat_o, wbm_sel_o
  );

endinterface

// File: rtl/wbm_timeout_cnt.sv
// Loadable down-counter with a zero flag; LIMIT = 0 disables it so the flag
// never asserts. A load followed by LIMIT decrement cycles raises zero_o.
module wbm_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  // Loading LIMIT-1 makes the flag rise in the LIMIT-th counted cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (LIMIT != 0) && (cnt_q == '0);

endmodule

// File: rtl/wbm_ctrl.sv
// Wishbone B4 classic single-transfer master: one request at a time, bounded
// RTY retry with a one-cycle backoff, watchdog abort, one-cycle response strobe.
module wbm_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W    = WB_ADDR_W,
  parameter int unsigned DATA_W    = WB_DATA_W,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wbm_ctrl_if.master bus
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

  wbm_state_e       state_q, state_d;
  wb_term_e         term;
  logic [RTY_W-1:0] retry_q;
  logic             expired;
  logic             accept, restart, retry, done_ok, done_err, done_to;

  logic              cyc_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdat_q, rdat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              rsp_valid_q, rsp_err_q, rsp_to_q;

  assign term = wb_term_decode(bus.wbm_err_i, bus.wbm_ack_i, bus.wbm_rty_i);

  wbm_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept || restart),
    .dec_i  (state_q == ST_BUS),
    .zero_o (expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    accept   = 1'b0;
    restart  = 1'b0;
    retry    = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          accept  = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        case (term)
          TERM_ERR: done_err = 1'b1;
          TERM_ACK: done_ok  = 1'b1;
          TERM_RTY: begin
            if (retry_q < RTY_LIMIT) retry    = 1'b1;
            else                     done_err = 1'b1;
          end
          default:  done_to = expired;
        endcase
        if (retry)                             state_d = ST_BACKOFF;
        else if (done_ok || done_err || done_to) state_d = ST_IDLE;
      end
      ST_BACKOFF: begin
        restart = 1'b1;
        state_d = ST_BUS;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset as well, so the bus shows zeros straight out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      rdat_q      <= '0;
      retry_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      rsp_valid_q <= done_ok || done_err || done_to;
      rsp_err_q   <= done_err || done_to;
      rsp_to_q    <= done_to;
      if (accept) begin
        cyc_q   <= 1'b1;
        we_q    <= bus.req_we_i;
        addr_q  <= bus.req_addr_i;
        wdat_q  <= bus.req_dat_i;
        sel_q   <= bus.req_sel_i;
        retry_q <= '0;
      end else if (restart) begin
        cyc_q <= 1'b1;
      end else if (retry || done_ok || done_err || done_to) begin
        cyc_q <= 1'b0;
      end
      if (retry) retry_q <= retry_q + RTY_W'(1);
      // Read data is only captured on a clean ACK; writes and errors keep the old value.
      if (done_ok && !we_q) rdat_q <= bus.wbm_dat_i;
    end
  end

  assign bus.req_ready_o   = (state_q == ST_IDLE);
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_dat_o     = rdat_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_to_q;
  assign bus.wbm_cyc_o     = cyc_q;
  assign bus.wbm_stb_o     = cyc_q;
  assign bus.wbm_we_o      = we_q;
  assign bus.wbm_addr_o    = addr_q;
  assign bus.wbm_dat_o     = wdat_q;
  assign bus.wbm_sel_o     = sel_q;

endmodule
